// File: rtl/issue_pkg.sv
// issue_pkg: MIPS decode helpers shared by the dual-issue scheduler.
//   Opcode/funct constants, scheduler state enum, and decode functions
//   dest_reg / src_regs / is_branch / is_mem / is_single_only.
package issue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LWR     = 6'h26;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  // REGIMM rt codes for the linking variants (BLTZAL/BGEZAL)
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {RUN, DS_WAIT, FLUSH} state_e;

  function automatic logic [5:0] op_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  // Architectural register written by inst (0 = none).
  function automatic logic [4:0] dest_reg(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (op == OP_SPECIAL)                       return inst[15:11];
    if (op >= OP_ADDI && op <= OP_LUI)          return inst[20:16];
    if (op >= OP_LB   && op <= OP_LWR)          return inst[20:16];
    if (op == OP_JAL)                           return REG_RA;
    if (op == OP_REGIMM &&
        (inst[20:16] == RT_BLTZAL || inst[20:16] == RT_BGEZAL))
                                                return REG_RA;
    return 5'd0;
  endfunction

  // {rs, rt}; compared unconditionally, which is conservative for I-type.
  function automatic logic [9:0] src_regs(input logic [31:0] inst);
    return inst[25:16];
  endfunction

  function automatic logic is_branch(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (op == OP_SPECIAL) return (inst[5:0] == FN_JR) || (inst[5:0] == FN_JALR);
    return (op == OP_REGIMM) || (op >= OP_J && op <= OP_BGTZ);
  endfunction

  // Loads and stores occupy opcodes 0x20-0x2f.
  function automatic logic is_mem(input logic [31:0] inst);
    return inst[31:30] == 2'b10;
  endfunction

  // HI/LO, mult/div, traps and COP0 (incl. ERET) never pair.
  function automatic logic is_single_only(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    if (op == OP_COP0) return 1'b1;
    if (op != OP_SPECIAL) return 1'b0;
    return (fn == FN_SYSCALL) || (fn == FN_BREAK) ||
           (fn >= FN_MFHI && fn <= FN_MTLO) ||
           (fn >= FN_MULT && fn <= FN_DIVU);
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: combinational pairing check for the two FIFO head entries.
//   inst1_i/inst2_i  head / head+1 instruction words
//   exp1_i/exp2_i    exception codes (0 = none)
//   one_left_i       only the head entry is present
//   can_dual_o       both entries may issue together this cycle
module issue_pair_check
  import issue_pkg::*;
#(
  parameter int EXP_W = 14
) (
  input  logic [31:0]      inst1_i,
  input  logic [31:0]      inst2_i,
  input  logic [EXP_W-1:0] exp1_i,
  input  logic [EXP_W-1:0] exp2_i,
  input  logic             one_left_i,
  output logic             can_dual_o
);

  logic [4:0] dst1, dst2, rs2, rt2;
  logic       raw, waw, hazard;

  always_comb begin
    dst1 = dest_reg(inst1_i);
    dst2 = dest_reg(inst2_i);
    {rs2, rt2} = src_regs(inst2_i);
    raw = (dst1 != 5'd0) && ((dst1 == rs2) || (dst1 == rt2));
    waw = (dst1 != 5'd0) && (dst1 == dst2);
    hazard = (exp1_i != '0) || (exp2_i != '0) || is_branch(inst2_i) || raw || waw ||
             (is_mem(inst1_i) && is_mem(inst2_i)) ||
             is_single_only(inst1_i) || is_single_only(inst2_i);

    can_dual_o = 1'b0;
    if (!one_left_i) begin
      // Branch + delay slot go together; only a faulting branch or a
      // link-register dependency splits them.
      if (is_branch(inst1_i)) can_dual_o = (exp1_i == '0) && !raw;
      else                    can_dual_o = !hazard;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue scheduler between instruction FIFO and ID/EX.
//   Inputs : clk, resetn (async low), fifo_empty, fifo_1_left, inst1/inst2,
//            inst_exp1/inst_exp2, id_stall, flush_req (1-cycle pulse).
//   Outputs: read_en1/read_en2 (combinational pops), master_is_branch,
//            fifo_flush/busy_flush (registered, high in FLUSH state).
//   Optional macro ISSUE_PERF_CNT_EN adds perf_dual/perf_single/perf_stall.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int EXP_W = 14,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fifo_empty,
  input  logic             fifo_1_left,
  input  logic [31:0]      inst1,
  input  logic [31:0]      inst2,
  input  logic [EXP_W-1:0] inst_exp1,
  input  logic [EXP_W-1:0] inst_exp2,
  input  logic             id_stall,
  input  logic             flush_req,
  output logic             read_en1,
  output logic             read_en2,
  output logic             master_is_branch,
  output logic             fifo_flush,
  output logic             busy_flush
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_dual,
  output logic [CNT_W-1:0] perf_single,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  state_e state_q;
  logic   flush_pending_q, fifo_flush_q, busy_flush_q;
  logic   can_dual, pop_ok, br1;

  issue_pair_check #(.EXP_W(EXP_W)) u_pair (
    .inst1_i   (inst1),
    .inst2_i   (inst2),
    .exp1_i    (inst_exp1),
    .exp2_i    (inst_exp2),
    .one_left_i(fifo_1_left),
    .can_dual_o(can_dual)
  );

  // resetn in the gate makes pops drop asynchronously with reset.
  always_comb begin
    br1      = is_branch(inst1);
    pop_ok   = resetn && !fifo_empty && !id_stall &&
               (state_q != FLUSH) && !fifo_flush_q;
    read_en1 = pop_ok;
    read_en2 = pop_ok && (state_q == RUN) && can_dual;
  end

  assign master_is_branch = br1;
  assign fifo_flush       = fifo_flush_q;
  assign busy_flush       = busy_flush_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= RUN;
      flush_pending_q <= 1'b0;
      fifo_flush_q    <= 1'b0;
      busy_flush_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // A redirect kills everything younger, including a branch popped now.
          if (flush_req) begin
            state_q      <= FLUSH;
            fifo_flush_q <= 1'b1;
            busy_flush_q <= 1'b1;
          end else if (read_en1 && !read_en2 && br1) begin
            state_q <= DS_WAIT;
          end
        end
        DS_WAIT: begin
          // Delay slot must issue before the flush may take effect.
          if (read_en1) begin
            if (flush_pending_q || flush_req) begin
              state_q      <= FLUSH;
              fifo_flush_q <= 1'b1;
              busy_flush_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else if (flush_req) begin
            flush_pending_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q         <= RUN;
          flush_pending_q <= 1'b0;
          fifo_flush_q    <= 1'b0;
          busy_flush_q    <= 1'b0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_dual_q, perf_single_q, perf_stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_dual_q   <= '0;
      perf_single_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (read_en2)                 perf_dual_q   <= perf_dual_q + 1'b1;
      if (read_en1 && !read_en2)    perf_single_q <= perf_single_q + 1'b1;
      if (!fifo_empty && !read_en1) perf_stall_q  <= perf_stall_q + 1'b1;
    end
  end

  assign perf_dual   = perf_dual_q;
  assign perf_single = perf_single_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fifo_empty, fifo_1_left, id_stall, flush_req;
  logic [31:0] inst1, inst2;
  logic [13:0] inst_exp1, inst_exp2;
  logic        read_en1, read_en2, master_is_branch, fifo_flush, busy_flush;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_dual, perf_single, perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic  r1;
    logic  r2;
    string nm;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  issue_ctrl #(.EXP_W(14), .CNT_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .fifo_empty      (fifo_empty),
    .fifo_1_left     (fifo_1_left),
    .inst1           (inst1),
    .inst2           (inst2),
    .inst_exp1       (inst_exp1),
    .inst_exp2       (inst_exp2),
    .id_stall        (id_stall),
    .flush_req       (flush_req),
    .read_en1        (read_en1),
    .read_en2        (read_en2),
    .master_is_branch(master_is_branch),
    .fifo_flush      (fifo_flush),
    .busy_flush      (busy_flush)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_dual       (perf_dual),
    .perf_single     (perf_single),
    .perf_stall      (perf_stall)
`endif
  );

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
    logic [4:0] s, t;
    s = rs[4:0]; t = rt[4:0];
    return {op, s, t, 16'h0004};
  endfunction

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_MFHI = 6'h10;

  logic [31:0] addu_a, addu_b, addu_c, beq_i, jal_i, lw_a, lw_b, mfhi_i;

  // One cycle: drive inputs just after negedge, check pops mid-cycle
  // against the scoreboard, then let the posedge update the FSM.
  task automatic step(input logic [31:0] i1, input logic [31:0] i2,
                      input logic emp, input logic ol, input logic stl, input logic fr,
                      input logic [13:0] x1, input logic [13:0] x2,
                      input logic er1, input logic er2, input string nm);
    exp_t e;
    inst1 = i1; inst2 = i2; fifo_empty = emp; fifo_1_left = ol;
    id_stall = stl; flush_req = fr; inst_exp1 = x1; inst_exp2 = x2;
    e.r1 = er1; e.r2 = er2; e.nm = nm;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    tests++;
    if ({read_en1, read_en2} !== {e.r1, e.r2}) begin
      fails++;
      $display("FAIL %s: read_en1/2=%b%b expected %b%b", e.nm, read_en1, read_en2, e.r1, e.r2);
    end
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reg(input logic ff, input logic bf, input string nm);
    tests++;
    if ({fifo_flush, busy_flush} !== {ff, bf}) begin
      fails++;
      $display("FAIL %s: fifo_flush/busy_flush=%b%b expected %b%b", nm, fifo_flush, busy_flush, ff, bf);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst1 = addu_a; inst2 = addu_b; fifo_empty = 1'b0; fifo_1_left = 1'b0;
    id_stall = 1'b0; flush_req = 1'b0; inst_exp1 = '0; inst_exp2 = '0;
    #1;
    tests++;
    if ({read_en1, read_en2} !== 2'b00) begin
      fails++;
      $display("FAIL reset_pops: read_en1/2=%b%b expected 00", read_en1, read_en2);
    end
    chk_reg(1'b0, 1'b0, "reset_flush");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_dual();
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 1, "dual_indep");
    tests++;
    inst1 = beq_i; #1;
    if (master_is_branch !== 1'b1) begin
      fails++;
      $display("FAIL master_branch: got %b expected 1", master_is_branch);
    end
  endtask

  task automatic test_hazards();
    step(rtype(1, 2, 3, F_ADDU), rtype(3, 5, 4, F_SUBU), 0, 0, 0, 0, '0, '0, 1, 0, "raw");
    step(rtype(3, 5, 4, F_SUBU), addu_c, 0, 0, 0, 0, '0, '0, 1, 1, "raw_next_dual");
    step(rtype(1, 2, 3, F_ADDU), rtype(7, 8, 3, F_ADDU), 0, 0, 0, 0, '0, '0, 1, 0, "waw");
    step(mfhi_i, addu_c, 0, 0, 0, 0, '0, '0, 1, 0, "hilo_single");
    step(addu_c, beq_i, 0, 0, 0, 0, '0, '0, 1, 0, "branch_slot2");
    step(beq_i, addu_a, 0, 0, 0, 0, '0, '0, 1, 1, "branch_ds_pair");
    // link dependency splits branch from its delay slot
    step(jal_i, rtype(31, 1, 5, F_ADDU), 0, 0, 0, 0, '0, '0, 1, 0, "jal_link_raw");
    step(rtype(31, 1, 5, F_ADDU), addu_c, 0, 0, 0, 0, '0, '0, 1, 0, "jal_ds_single");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 1, "jal_back_run");
  endtask

  task automatic test_delay_slot();
    step(beq_i, 32'h0, 0, 1, 0, 0, '0, '0, 1, 0, "beq_one_left");
    step(32'h0, 32'h0, 1, 0, 0, 0, '0, '0, 0, 0, "ds_empty");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 0, "ds_single");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 1, "ds_back_run");
    // faulting branch: delay slot issues separately
    step(beq_i, addu_a, 0, 0, 0, 0, 14'h1, '0, 1, 0, "beq_exp1");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 0, "beq_exp1_ds");
  endtask

  task automatic test_flush();
    step(beq_i, 32'h0, 0, 1, 0, 0, '0, '0, 1, 0, "fl_beq");
    step(32'h0, 32'h0, 1, 0, 0, 1, '0, '0, 0, 0, "fl_req_dswait");
    chk_reg(1'b0, 1'b0, "fl_deferred");
    step(32'h0, 32'h0, 0, 0, 0, 0, '0, '0, 1, 0, "fl_ds_pop");
    chk_reg(1'b1, 1'b1, "fl_active");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 0, 0, "fl_no_pop");
    chk_reg(1'b0, 1'b0, "fl_one_cycle");
    step(addu_a, addu_b, 0, 0, 0, 1, '0, '0, 1, 1, "fl_run_with_pop");
    chk_reg(1'b1, 1'b1, "fl_run_active");
    step(addu_a, addu_b, 0, 0, 0, 1, '0, '0, 0, 0, "fl_in_flush");
    chk_reg(1'b0, 1'b0, "fl_req_ignored");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 1, "fl_resume");
  endtask

  task automatic test_single_cases();
    step(lw_a, lw_b, 0, 0, 0, 0, '0, '0, 1, 0, "two_mem");
    step(addu_a, addu_b, 0, 0, 0, 0, '0, 14'h4, 1, 0, "exp2");
    step(addu_a, addu_b, 0, 0, 1, 0, '0, '0, 0, 0, "id_stall");
    step(addu_a, addu_b, 1, 0, 0, 0, '0, '0, 0, 0, "fifo_empty");
  endtask

  task automatic test_reset_mid_op();
    step(beq_i, 32'h0, 0, 1, 0, 0, '0, '0, 1, 0, "rm_beq");
    step(32'h0, 32'h0, 1, 0, 0, 1, '0, '0, 0, 0, "rm_pending");
    inst1 = addu_a; inst2 = addu_b; fifo_empty = 1'b0; fifo_1_left = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    tests++;
    if ({read_en1, read_en2} !== 2'b00) begin
      fails++;
      $display("FAIL rm_async: read_en1/2=%b%b expected 00", read_en1, read_en2);
    end
    @(negedge clk);
    resetn = 1'b1;
    step(addu_a, addu_b, 0, 0, 0, 0, '0, '0, 1, 1, "rm_run_after");
    chk_reg(1'b0, 1'b0, "rm_no_stale_flush");
  endtask

  initial begin
    addu_a = rtype(7, 8, 6, F_ADDU);
    addu_b = rtype(10, 11, 9, F_ADDU);
    addu_c = rtype(13, 14, 12, F_ADDU);
    beq_i  = itype(6'h04, 1, 2);
    jal_i  = {6'h03, 26'h10};
    lw_a   = itype(6'h23, 10, 20);
    lw_b   = itype(6'h23, 12, 21);
    mfhi_i = rtype(0, 0, 15, F_MFHI);
    test_reset();
    test_dual();
    @(negedge clk);
    test_hazards();
    test_delay_slot();
    test_flush();
    test_single_cases();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
